// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the fixed-length UART frame link (rx and tx framers).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_TERM    = 2'd2,
        ST_RESYNC  = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_LONG    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_TERMINATOR   = 8'h0A;
    // 100 MHz / 9600 baud
    localparam int         DEFAULT_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/uart_frame_rx_uart.sv
// 8N1 UART byte receiver with a 2-flop input synchroniser and mid-bit sampling.
// Latency: data_vld pulses for one clk, shortly after the middle of the stop bit.
// Backpressure: none; bytes with a low stop bit are dropped silently.
module uart_frame_rx_uart
    import uart_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_vld
);

    localparam int             CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          vld_q, vld_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        case (state_q)
            RX_IDLE: begin
                // The detection cycle counts as the first cycle of the start bit.
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = CW'(1);
                end
            end
            RX_START: begin
                if (cnt_q >= HALF) begin
                    if (!rx_sync_q) begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    if (rx_sync_q) begin
                        vld_d  = 1'b1;
                        data_d = shreg_q;
                    end
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
        end
    end

    assign data_out = data_q;
    assign data_vld = vld_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Fixed-length UART frame receiver: NUM_BYTES payload bytes then TERMINATOR, validated and flattened.
// Latency: frame_valid / frame_err assert one clk after the deciding byte strobe.
// Backpressure: none; bad frames are discarded with a single error pulse.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int         NUM_BYTES      = 7,
    parameter logic [7:0] TERMINATOR     = DEFAULT_TERMINATOR,
    parameter int         TIMEOUT_CYCLES = 2_000_000,
    parameter int         CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [8*NUM_BYTES-1:0] frame_data,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic [7:0]             frame_count,
    output logic                   busy
);

    localparam int IW = $clog2(NUM_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0] byte_dat;
    logic       byte_vld;

    uart_frame_rx_uart #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data_out (byte_dat),
        .data_vld (byte_vld)
    );

    frame_state_t           state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [8*NUM_BYTES-1:0] asm_q, asm_d;
    logic [8*NUM_BYTES-1:0] frame_data_q, frame_data_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [7:0]             frame_count_q, frame_count_d;

    logic is_term;
    logic expired;

    assign is_term = (byte_dat == TERMINATOR);
    assign expired = (timer_q == '0);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        asm_d         = asm_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_vld && !is_term) begin
                    asm_d[7:0] = byte_dat;
                    idx_d      = IW'(1);
                    timer_d    = TW'(TIMEOUT_CYCLES);
                    state_d    = (NUM_BYTES == 1) ? ST_TERM : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (byte_vld) begin
                    timer_d = TW'(TIMEOUT_CYCLES);
                    if (is_term) begin
                        err_code_d  = ERR_SHORT;
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        for (int k = 0; k < NUM_BYTES; k++) begin
                            if (idx_q == IW'(k)) begin
                                asm_d[8*k +: 8] = byte_dat;
                            end
                        end
                        idx_d = idx_q + IW'(1);
                        if (idx_q == IW'(NUM_BYTES - 1)) begin
                            state_d = ST_TERM;
                        end
                    end
                end else if (expired) begin
                    err_code_d  = ERR_TIMEOUT;
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_TERM: begin
                if (byte_vld) begin
                    timer_d = TW'(TIMEOUT_CYCLES);
                    if (is_term) begin
                        frame_data_d  = asm_q;
                        frame_valid_d = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                        state_d       = ST_IDLE;
                    end else begin
                        err_code_d  = ERR_LONG;
                        frame_err_d = 1'b1;
                        state_d     = ST_RESYNC;
                    end
                end else if (expired) begin
                    err_code_d  = ERR_TIMEOUT;
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_RESYNC: begin
                // The overlong frame was already reported; leaving here is silent.
                if (byte_vld) begin
                    timer_d = TW'(TIMEOUT_CYCLES);
                    if (is_term) begin
                        state_d = ST_IDLE;
                    end
                end else if (expired) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            asm_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            asm_q         <= asm_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: good, short, long, timeout, reset-mid-frame and counter wrap.
module tb_uart_frame_rx;

    localparam int CPB     = 3;
    localparam int TIMEOUT = 200;
    localparam int NB      = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic [8*NB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_err;
    logic [1:0]    err_code;
    logic [7:0]    frame_count;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int vcnt = 0;
    int ecnt = 0;
    int v0;
    int e0;

    uart_frame_rx #(
        .NUM_BYTES      (NB),
        .TERMINATOR     (8'h0A),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CLKS_PER_BIT   (CPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) vcnt = vcnt + 1;
        if (frame_err)   ecnt = ecnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = 1'b1;
        idle(CPB);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic mark();
        v0 = vcnt;
        e0 = ecnt;
    endtask

    initial begin
        idle(5);
        reset = 1'b0;
        check("rst_data",  64'(frame_data), 64'h0);
        check("rst_valid", 64'(frame_valid), 64'h0);
        check("rst_err",   64'(frame_err), 64'h0);
        check("rst_code",  64'(err_code), 64'h0);
        check("rst_count", 64'(frame_count), 64'h0);
        check("rst_busy",  64'(busy), 64'h0);

        // 1: good frame
        mark();
        send_str("1234567\n");
        idle(10);
        check("t1_valid", 64'(vcnt - v0), 64'd1);
        check("t1_err",   64'(ecnt - e0), 64'd0);
        check("t1_data",  64'(frame_data), 64'h37363534333231);
        check("t1_count", 64'(frame_count), 64'd1);
        check("t1_busy",  64'(busy), 64'h0);

        // 2: short frame, then good
        mark();
        send_str("123\n");
        idle(10);
        check("t2_err",   64'(ecnt - e0), 64'd1);
        check("t2_code",  64'(err_code), 64'h1);
        check("t2_valid", 64'(vcnt - v0), 64'd0);
        check("t2_data",  64'(frame_data), 64'h37363534333231);
        mark();
        send_str("ABCDEFG\n");
        idle(10);
        check("t2b_valid", 64'(vcnt - v0), 64'd1);
        check("t2b_data",  64'(frame_data), 64'h47464544434241);
        check("t2b_count", 64'(frame_count), 64'd2);
        check("t2b_code",  64'(err_code), 64'h1);

        // 3: long frame, resync, then good
        mark();
        send_str("12345678");
        idle(10);
        check("t3_err",   64'(ecnt - e0), 64'd1);
        check("t3_code",  64'(err_code), 64'h2);
        check("t3_valid", 64'(vcnt - v0), 64'd0);
        check("t3_busy",  64'(busy), 64'h1);
        send_str("\n");
        idle(10);
        check("t3_valid_nl", 64'(vcnt - v0), 64'd0);
        check("t3_err_nl",   64'(ecnt - e0), 64'd1);
        check("t3_busy_nl",  64'(busy), 64'h0);
        mark();
        send_str("7654321\n");
        idle(10);
        check("t3b_valid", 64'(vcnt - v0), 64'd1);
        check("t3b_data",  64'(frame_data), 64'h31323334353637);
        check("t3b_count", 64'(frame_count), 64'd3);

        // 4: inter-byte timeout
        mark();
        send_str("12");
        idle(TIMEOUT / 2);
        check("t4_early", 64'(ecnt - e0), 64'd0);
        idle(TIMEOUT * 2);
        check("t4_err",   64'(ecnt - e0), 64'd1);
        check("t4_code",  64'(err_code), 64'h3);
        check("t4_busy",  64'(busy), 64'h0);
        check("t4_data",  64'(frame_data), 64'h31323334353637);
        mark();
        send_str("\n");
        idle(10);
        check("t4_nl_err",   64'(ecnt - e0), 64'd0);
        check("t4_nl_valid", 64'(vcnt - v0), 64'd0);

        // 5: reset after the 4th byte of a frame
        mark();
        send_str("1234");
        pulse_reset();
        check("t5_data",  64'(frame_data), 64'h0);
        check("t5_count", 64'(frame_count), 64'h0);
        check("t5_code",  64'(err_code), 64'h0);
        check("t5_busy",  64'(busy), 64'h0);
        check("t5_valid", 64'(frame_valid), 64'h0);
        idle(TIMEOUT * 2);
        check("t5_noerr", 64'(ecnt - e0), 64'd0);
        send_str("1234567\n");
        idle(10);
        check("t5b_valid", 64'(vcnt - v0), 64'd1);
        check("t5b_count", 64'(frame_count), 64'd1);
        check("t5b_data",  64'(frame_data), 64'h37363534333231);

        // 6: frame_count wrap from a clean reset
        pulse_reset();
        mark();
        for (int f = 0; f < 255; f++) send_str("1234567\n");
        idle(10);
        check("t6_count255", 64'(frame_count), 64'd255);
        send_str("ABCDEFG\n");
        idle(10);
        check("t6_valid", 64'(vcnt - v0), 64'd256);
        check("t6_err",   64'(ecnt - e0), 64'd0);
        check("t6_count", 64'(frame_count), 64'd0);
        check("t6_data",  64'(frame_data), 64'h47464544434241);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
